// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared constants for the backing-memory arbiter.
//   REQ_I / REQ_D : requester ids, also the encoding of the last-grant bit.
//   WORD_BYTES    : bytes per memory beat.
//   ST_*          : arbiter state codes. The read states are split into a REQ
//                   substate (beat offered to memory) and a RESP substate
//                   (waiting for the read response).
package mem_arb_pkg;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int WORD_BYTES = 4;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t ST_IDLE   = 3'd0;
   localparam arb_state_t ST_I_REQ  = 3'd1;
   localparam arb_state_t ST_I_RESP = 3'd2;
   localparam arb_state_t ST_D_REQ  = 3'd3;
   localparam arb_state_t ST_D_RESP = 3'd4;
   localparam arb_state_t ST_D_WR   = 3'd5;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: beat-level port between the arbiter and backing memory.
//   req/we/addr/wdata/wstrb : beat offered by the arbiter
//   gnt                     : memory accepts the beat
//   rvalid/rdata            : read response
// Handshake: a beat transfers on the rising edge where req && gnt. Once req
// is raised, req and the whole payload hold steady until that edge. Every
// accepted read returns exactly one rvalid/rdata, in order, with no
// backpressure; writes return nothing.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              gnt;
   logic              rvalid;
   logic [31:0]       rdata;

   modport master (output req, we, addr, wdata, wstrb,
                   input  gnt, rvalid, rdata);

   modport slave  (input  req, we, addr, wdata, wstrb,
                   output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: combinational 2-way round-robin chooser.
//   i_req, d_req : pending requests
//   last_grant   : side served most recently (REQ_I / REQ_D)
//   grant_vld    : at least one request pending
//   grant_id     : chosen side; on a tie the side not served last wins
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_grant,
   output logic grant_vld,
   output logic grant_id
);

   always_comb begin
      grant_vld = i_req | d_req;
      if (i_req && d_req) begin
         grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
      end else if (d_req) begin
         grant_id = REQ_D;
      end else begin
         grant_id = REQ_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between the I-cache refill
// path and the D-cache path (line refills and single-word stores).
//   clk, rst        : clock, asynchronous active-low reset
//   i_req/i_addr    : I-side line refill request, held until i_done
//   d_req/d_we/...  : D-side request (refill or store), held until d_done
//   i_rvalid/d_rvalid, rdata, rbeat : returned refill beat for the owner
//   i_done/d_done   : one-cycle completion pulses
//   busy            : a transaction is in progress
//   dbg_state       : current state code (ST_* in mem_arb_pkg)
//   dbg_last_grant  : side served most recently
//   mem             : beat-level memory port (master side)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_req,
   input  logic [ADDR_W-1:0]             i_addr,
   input  logic                          d_req,
   input  logic                          d_we,
   input  logic [ADDR_W-1:0]             d_addr,
   input  logic [31:0]                   d_wdata,
   input  logic [3:0]                    d_wstrb,
   output logic                          i_rvalid,
   output logic                          d_rvalid,
   output logic [31:0]                   rdata,
   output logic [$clog2(LINE_WORDS)-1:0] rbeat,
   output logic                          i_done,
   output logic                          d_done,
   output logic                          busy,
   output logic [2:0]                    dbg_state,
   output logic                          dbg_last_grant,
   mem_arbiter_if.master                 mem
);

   localparam int BEAT_W   = $clog2(LINE_WORDS);
   localparam int WORD_OFF = $clog2(WORD_BYTES);
   localparam int LINE_OFF = BEAT_W + WORD_OFF;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   arb_state_t                 state;
   logic                       last_grant;
   logic [BEAT_W-1:0]          beat;
   logic [ADDR_W-1:WORD_OFF]   word_addr;
   logic [31:0]                wdata_q;
   logic [3:0]                 wstrb_q;
   logic                       pick_vld;
   logic                       pick_id;
   logic [ADDR_W-1:0]          line_beat_addr;
   logic [ADDR_W-1:0]          store_addr;

   // Byte-offset bits never matter: beats are always word aligned.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[WORD_OFF-1:0], d_addr[WORD_OFF-1:0]};

   mem_arb_pick u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant_vld  (pick_vld),
      .grant_id   (pick_id)
   );

   // Line base with the beat index spliced into the word-offset field.
   assign line_beat_addr = {word_addr[ADDR_W-1:LINE_OFF], beat, {WORD_OFF{1'b0}}};
   assign store_addr     = {word_addr, {WORD_OFF{1'b0}}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         last_grant <= REQ_I;
         beat       <= '0;
         word_addr  <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata      <= '0;
         rbeat      <= '0;
         i_rvalid   <= 1'b0;
         d_rvalid   <= 1'b0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_done   <= 1'b0;
         d_done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  last_grant <= pick_id;
                  beat       <= '0;
                  if (pick_id == REQ_I) begin
                     word_addr <= i_addr[ADDR_W-1:WORD_OFF];
                     state     <= ST_I_REQ;
                  end else begin
                     word_addr <= d_addr[ADDR_W-1:WORD_OFF];
                     wdata_q   <= d_wdata;
                     wstrb_q   <= d_wstrb;
                     state     <= d_we ? ST_D_WR : ST_D_REQ;
                  end
               end
            end
            ST_I_REQ: if (mem.gnt) state <= ST_I_RESP;
            ST_D_REQ: if (mem.gnt) state <= ST_D_RESP;
            ST_I_RESP, ST_D_RESP: begin
               if (mem.rvalid) begin
                  rdata <= mem.rdata;
                  rbeat <= beat;
                  if (state == ST_I_RESP) i_rvalid <= 1'b1;
                  else                    d_rvalid <= 1'b1;
                  if (beat == LAST_BEAT) begin
                     // Done rides along with the final beat.
                     if (state == ST_I_RESP) i_done <= 1'b1;
                     else                    d_done <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     beat  <= beat + 1'b1;
                     state <= (state == ST_I_RESP) ? ST_I_REQ : ST_D_REQ;
                  end
               end
            end
            ST_D_WR: begin
               // Stores get no response; acceptance completes them.
               if (mem.gnt) begin
                  d_done <= 1'b1;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Memory-side outputs decode purely from state and latched fields, so
   // they cannot move while a beat waits for gnt.
   always_comb begin
      mem.req  = 1'b0;
      mem.we   = 1'b0;
      mem.addr = '0;
      case (state)
         ST_I_REQ, ST_D_REQ: begin
            mem.req  = 1'b1;
            mem.addr = line_beat_addr;
         end
         ST_I_RESP, ST_D_RESP: mem.addr = line_beat_addr;
         ST_D_WR: begin
            mem.req  = 1'b1;
            mem.we   = 1'b1;
            mem.addr = store_addr;
         end
         default: ;
      endcase
   end

   assign mem.wdata      = wdata_q;
   assign mem.wstrb      = wstrb_q;
   assign busy           = (state != ST_IDLE);
   assign dbg_state      = state;
   assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives both cache requesters and a behavioural memory,
// and predicts grants, beat addresses, returned data and done pulses from
// transaction-level rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_rvalid, d_rvalid, i_done, d_done, busy, dbg_last_grant;
  logic [31:0] rdata;
  logic [1:0]  rbeat;
  logic [2:0]  dbg_state;

  mem_arbiter_if #(.ADDR_W(32)) mem_bus ();

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rdata(rdata), .rbeat(rbeat),
    .i_done(i_done), .d_done(d_done), .busy(busy),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant),
    .mem(mem_bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_addr_q[$];
  logic        grant_log[$];

  bit          model_busy, model_owner, model_last, model_we;
  int          beat_k, txn_count;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstrb;
  bit          exp_i_rv, exp_d_rv, exp_i_done, exp_d_done;
  logic [31:0] exp_rdata;
  int          exp_rbeat;
  bit          i_drop, d_drop;
  int          i_done_cyc, d_done_cyc, t0;

  // memory model
  bit          pend, pend_stale, stall_prev;
  int          rv_wait, gnt_wait;
  logic [31:0] pend_addr, stall_addr;
  bit          rand_lat, slow_beat2;
  int          gnt_lat, rv_lat, stray_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic pick_owner(input bit want_i, input bit want_d, input logic last);
    if (want_i && want_d) return (last == REQ_I) ? REQ_D : REQ_I;
    return want_d ? REQ_D : REQ_I;
  endfunction

  function automatic int next_gnt_lat();
    return rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
  endfunction

  function automatic int next_rv_lat(input int k);
    if (slow_beat2 && k == 2) return 5;
    return rand_lat ? int'($urandom_range(0, 3)) : rv_lat;
  endfunction

  task automatic model_reset();
    model_busy = 0; model_owner = REQ_I; model_last = REQ_I; model_we = 0;
    beat_k = 0; exp_addr_q.delete();
    exp_i_rv = 0; exp_d_rv = 0; exp_i_done = 0; exp_d_done = 0;
    stall_prev = 0; gnt_wait = 0;
  endtask

  task automatic start_txn(input bit ci, input bit cd, input bit cwe,
                           input logic [31:0] cia, input logic [31:0] cda,
                           input logic [31:0] cwd, input logic [3:0] cws);
    logic [31:0] base;
    model_owner = pick_owner(ci, cd, model_last);
    model_last  = model_owner;
    model_busy  = 1;
    txn_count++;
    beat_k = 0;
    exp_addr_q.delete();
    grant_log.push_back(dbg_last_grant);
    check_eq("last_grant", dbg_last_grant, model_owner);
    if (model_owner == REQ_D && cwe) begin
      model_we = 1;
      exp_addr_q.push_back((cda / 4) * 4);
      exp_wdata = cwd;
      exp_wstrb = cws;
    end else begin
      model_we = 0;
      base = (model_owner == REQ_I) ? cia : cda;
      base = (base / (LW * 4)) * (LW * 4);
      for (int k = 0; k < LW; k++) exp_addr_q.push_back(base + 32'(k * 4));
    end
    gnt_wait = next_gnt_lat();
  endtask

  // One clock: check the cache side, detect grants, run the memory model.
  task automatic step();
    bit was_idle, ci, cd, cwe;
    logic [31:0] cia, cda, cwd;
    logic [3:0] cws;
    was_idle = !model_busy;
    ci = i_req; cd = d_req; cwe = d_we;
    cia = i_addr; cda = d_addr; cwd = d_wdata; cws = d_wstrb;
    @(posedge clk); #1;
    cyc++;
    i_drop = 0; d_drop = 0;

    check_eq("i_rvalid", i_rvalid, exp_i_rv);
    check_eq("d_rvalid", d_rvalid, exp_d_rv);
    check_eq("i_done", i_done, exp_i_done);
    check_eq("d_done", d_done, exp_d_done);
    if (exp_i_rv || exp_d_rv) begin
      check_eq("rdata", rdata, exp_rdata);
      check_eq("rbeat", rbeat, exp_rbeat);
    end
    if (i_done) i_done_cyc = cyc;
    if (d_done) d_done_cyc = cyc;
    if (exp_i_done) begin model_busy = 0; i_req = 0; i_drop = 1; end
    if (exp_d_done) begin model_busy = 0; d_req = 0; d_drop = 1; end
    exp_i_rv = 0; exp_d_rv = 0; exp_i_done = 0; exp_d_done = 0;

    if (was_idle) begin
      check_eq("req_after_idle", mem_bus.req, ci | cd);
      check_eq("busy", busy, ci | cd);
      check_eq("state_idle", dbg_state == ST_IDLE, !(ci | cd));
      if (ci | cd) start_txn(ci, cd, cwe, cia, cda, cwd, cws);
    end

    // read response channel
    mem_bus.rvalid = 0;
    if (pend) begin
      if (rv_wait == 0) begin
        mem_bus.rvalid = 1;
        mem_bus.rdata  = mem_word(pend_addr);
        pend = 0;
        if (!pend_stale) begin
          exp_rdata = mem_word(pend_addr);
          exp_rbeat = beat_k;
          if (model_owner == REQ_I) exp_i_rv = 1; else exp_d_rv = 1;
          if (beat_k == LW - 1) begin
            if (model_owner == REQ_I) exp_i_done = 1; else exp_d_done = 1;
          end
          beat_k++;
        end
        pend_stale = 0;
      end else begin
        rv_wait--;
      end
    end else if ((stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0)) &&
                 (!model_busy || model_we)) begin
      mem_bus.rvalid = 1;
      mem_bus.rdata  = $urandom;
    end

    // request/grant channel
    mem_bus.gnt = 0;
    if (mem_bus.req) begin
      if (stall_prev) check_eq("stall_addr_stable", mem_bus.addr, stall_addr);
      if (gnt_wait == 0) begin
        mem_bus.gnt = 1;
        stall_prev = 0;
        check_eq("beat_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) check_eq("beat_addr", mem_bus.addr, exp_addr_q.pop_front());
        check_eq("beat_we", mem_bus.we, model_we);
        if (model_we) begin
          check_eq("wdata", mem_bus.wdata, exp_wdata);
          check_eq("wstrb", mem_bus.wstrb, exp_wstrb);
          exp_d_done = 1;
        end else begin
          pend = 1;
          pend_stale = 0;
          pend_addr = mem_bus.addr;
          rv_wait = next_rv_lat(beat_k);
        end
        gnt_wait = next_gnt_lat();
      end else begin
        gnt_wait--;
        stall_prev = 1;
        stall_addr = mem_bus.addr;
      end
    end else begin
      stall_prev = 0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (!model_busy && !i_req && !d_req && !pend) return;
    end
    check_eq("wait_bound", {31'd0, model_busy | i_req | d_req | pend}, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_mem_req"}, mem_bus.req, 0);
    check_eq({tag, "_mem_we"}, mem_bus.we, 0);
    check_eq({tag, "_mem_addr"}, mem_bus.addr, 0);
    check_eq({tag, "_rvalid"}, {i_rvalid, d_rvalid}, 0);
    check_eq({tag, "_done"}, {i_done, d_done}, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int txn_goal;
    rst = 0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0;
    pend = 0; pend_stale = 0; rand_lat = 0; slow_beat2 = 0;
    gnt_lat = 0; rv_lat = 0; stray_mode = 0; txn_count = 0;
    i_done_cyc = -1; d_done_cyc = -1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check_eq("reset_rdata", rdata, 0);
    check_eq("reset_rbeat", rbeat, 0);
    check_eq("reset_wdata", mem_bus.wdata, 0);
    check_eq("reset_wstrb", mem_bus.wstrb, 0);
    @(negedge clk);
    rst = 1;
    step(); step();

    // Simultaneous requests twice: D wins the first tie after reset.
    for (int r = 0; r < 2; r++) begin
      i_req = 1; i_addr = 32'h0000_4400 + 32'(r * 32'h100);
      d_req = 1; d_we = 0; d_addr = 32'h0000_8810 + 32'(r * 32'h100);
      wait_idle(200);
      check_eq("tie_last_is_i", dbg_last_grant, REQ_I);
    end
    check_eq("tie_log_len", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check_eq("tie0_d", grant_log[0], REQ_D);
      check_eq("tie0_i", grant_log[1], REQ_I);
      check_eq("tie1_d", grant_log[2], REQ_D);
      check_eq("tie1_i", grant_log[3], REQ_I);
    end

    // I refill at 0x1234, best-case memory.
    i_req = 1; i_addr = 32'h0000_1234; t0 = cyc;
    wait_idle(100);
    check_eq("i_done_cycle", i_done_cyc - t0, 9);

    // Store with gnt held off three cycles, stray rvalids thrown in.
    gnt_lat = 3; stray_mode = 2;
    d_req = 1; d_we = 1; d_addr = 32'h0000_2007; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b0011; t0 = cyc;
    wait_idle(100);
    check_eq("wr_stall_done_cycle", d_done_cyc - t0, 5);
    repeat (4) step();
    stray_mode = 0; gnt_lat = 0;

    // Best-case store.
    d_req = 1; d_we = 1; d_addr = 32'h0000_3FFC; d_wdata = 32'h1234_5678; d_wstrb = 4'b1111; t0 = cyc;
    wait_idle(100);
    check_eq("wr_done_cycle", d_done_cyc - t0, 2);

    // Response for beat 2 held back five extra cycles.
    slow_beat2 = 1;
    i_req = 1; i_addr = 32'h0000_3008; t0 = cyc;
    wait_idle(100);
    check_eq("slow_done_cycle", i_done_cyc - t0, 14);
    slow_beat2 = 0;

    // Reset during beat 1 of a D refill.
    d_req = 1; d_we = 0; d_addr = 32'h0000_5A44;
    for (int n = 0; n < 40 && beat_k < 1; n++) step();
    step();
    check_eq("midrst_busy_before", busy, 1);
    #2 rst = 0;
    #1;
    check_outputs_zero("midrst");
    check_eq("midrst_rdata", rdata, 0);
    check_eq("midrst_rbeat", rbeat, 0);
    d_req = 0; mem_bus.gnt = 0; mem_bus.rvalid = 0;
    @(posedge clk); #1;
    check_outputs_zero("midrst_hold");
    check_eq("midrst_last_grant", dbg_last_grant, REQ_I);
    @(negedge clk);
    rst = 1;
    model_reset();
    pend = 1; pend_stale = 1; rv_wait = 0; pend_addr = 32'h0000_5A44;
    repeat (5) step();

    // Randomized traffic.
    rand_lat = 1; stray_mode = 1;
    txn_goal = txn_count + 60;
    for (int c = 0; c < 6000 && txn_count < txn_goal; c++) begin
      step();
      if (!i_req && !i_drop && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && !d_drop && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = ($urandom_range(0, 2) == 0);
        d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
    end
    check_eq("random_txns_reached", txn_count >= txn_goal, 1);
    stray_mode = 0;
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single backing-memory port between the instruction-cache refill path and the data-cache path (line refills plus single-word write-through stores) of the pipelined RV32I core. Requesters hold a request until `done`. The arbiter then sequences the burst one beat at a time over a valid/grant/rvalid memory handshake and returns read beats to the owning cache. Sits between both caches and memory; cache-side `done` feeds the pipeline controller's `waiting`/stall logic.

## Interface
- `LINE_WORDS`, 4: words per cache line; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-cache line refill request, held until `i_done`.
- `i_addr` in ADDR_W: I-side miss address; line offset ignored.
- `d_req` in 1: D-cache request, held until `d_done`.
- `d_we` in 1: 1 = single-word write, 0 = line refill.
- `d_addr` in ADDR_W: D-side address; bits [1:0] ignored.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: store byte enables.
- `i_rvalid`, `d_rvalid` out 1: one refill beat is valid on `rdata`/`rbeat`.
- `rdata` out 32: returned word, shared by both sides.
- `rbeat` out log2(LINE_WORDS): word index of the returned beat.
- `i_done`, `d_done` out 1: one-cycle completion pulse.
- `busy` out 1: state ≠ IDLE.
- `mem_req` out 1: beat request.
- `mem_we` out 1: beat is a write.
- `mem_addr` out ADDR_W: word-aligned beat address.
- `mem_wdata` out 32, `mem_wstrb` out 4: write payload.
- `mem_gnt` in 1: memory accepts the beat when `mem_req && mem_gnt`.
- `mem_rvalid` in 1, `mem_rdata` in 32: read response; exactly one per accepted read, in order.

## Operation
- States: IDLE, I_RD, D_RD, D_WR. Each read state has substates REQ (drive `mem_req`, wait for `mem_gnt`) and RESP (wait for `mem_rvalid`).
- IDLE arbitration:
  - Only one request: grant it.
  - Both requests: grant the side not served last (`last_grant` bit, updated on every grant; reset = I, so the first tie goes to D).
  - D grant goes to D_WR if `d_we`, otherwise D_RD.
- Latch at grant: line base = addr with bits [log2(LINE_WORDS)+1:0] cleared; also latch `d_wdata`/`d_wstrb`. Beat counter cleared.
- Read beat address = base + beat·4. On `mem_rvalid` in RESP:
  - Register `rdata` ← `mem_rdata`, `rbeat` ← beat, and assert the owner's `x_rvalid` next cycle.
  - If beat = LINE_WORDS-1: pulse `x_done` together with that final `x_rvalid` and return to IDLE. Otherwise increment the beat and return to REQ.
- D_WR: single beat with `mem_we`=1 and `mem_addr` = {d_addr[ADDR_W-1:2], 2'b00}. On `mem_gnt`, pulse `d_done` next cycle and go to IDLE. No response is expected.
- Requests are sampled only in IDLE. A request dropped mid-transaction does not abort it; the burst completes and still pulses done.
- `mem_rvalid` outside a RESP substate is ignored.
- Outputs are Moore/registered; `mem_*` are decoded from state and latched fields only.

## Timing
- Reset values: `mem_req`, `mem_we`, `i_rvalid`, `d_rvalid`, `i_done`, `d_done`, `busy` = 0; `rdata`, `rbeat`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0; state = IDLE, `last_grant` = I, beat = 0.
- A request seen in IDLE at cycle 0 drives `mem_req` at cycle 1.
- Per read beat, with immediate `mem_gnt` and `mem_rvalid` one cycle later: 2 cycles. The next `mem_req` comes the cycle after `mem_rvalid`.
- LINE_WORDS=4 best case: `mem_req` at cycles 1, 3, 5, 7; `x_rvalid` at 3, 5, 7, 9; `x_done` at 9; IDLE at 9; next grant's `mem_req` at 10.
- Write best case: `mem_req` at cycle 1, `d_done` at cycle 2.
- `mem_req` and the payload stay stable until `mem_gnt`.
- Reset asserted mid-burst: immediate return to IDLE; no done pulse; outstanding responses after release are ignored.

## Structure
- `mem_arb_pkg`: state enum, `REQ_I`/`REQ_D` id constants, `WORD_BYTES`=4.
- Sub-module `mem_arb_pick`: 2-way round-robin chooser (inputs `i_req`, `d_req`, `last_grant`; outputs grant valid and grant id), purely combinational.

## Test plan
- `i_req` alone, `i_addr`=0x1234, immediate gnt and rvalid → `mem_addr` sequence 0x1230, 0x1234, 0x1238, 0x123C; `i_rvalid` with `rbeat` 0–3; `i_done` at cycle 9.
- `d_req` write, `d_addr`=0x2007, wstrb=4'b0011, `mem_gnt` held low for 3 cycles → request and payload stable; `mem_addr`=0x2004; `d_done` the cycle after gnt.
- `i_req` and `d_req` raised together twice in a row → D is served first, then I; `last_grant` alternates.
- `mem_rvalid` delayed by 5 cycles on beat 2 → no `x_rvalid` or done until it arrives; the beat index is preserved.
- Reset pulsed low while in beat 1 of a D refill → all outputs zero immediately; IDLE; no `d_done`.
- Stray `mem_rvalid` in IDLE or during a write → no `rvalid` or `done` output.
